pika_dmem_bank: RTL and testbench

//  Parametrised data memory for the PikaRISC bench and SoC; successor to the fixed combinational data memory.

---
 rtl/pika_dmem_pkg.sv | 24 ++
 rtl/pika_dmem_wait_ctr.sv | 29 ++
 rtl/pika_dmem_bank.sv | 162 ++++++++++++++++
 tb/tb_pika_dmem_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pika_dmem_pkg.sv
// Shared definitions for the PikaRISC data memory bank: FSM state encoding,
// wait-counter width and a constant-evaluable ceil(log2) helper used to derive
// the lane-offset and word-index widths.
package pika_dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    // Wait-state counter width; WAIT_STATES is limited to 0..15.
    localparam int CTR_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pika_dmem_wait_ctr.sv
// Loadable 4-bit down-counter that paces the wait states between request
// accept and response. Saturates at zero; 'zero' flags the final wait cycle.
module pika_dmem_wait_ctr
    import pika_dmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CTR_W-1:0] count;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pika_dmem_bank.sv
// PikaRISC data memory bank: valid/ready request channel, WAIT_STATES cycles of
// latency padding, byte-lane stores and out-of-range error reporting.
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, a request whose
// address is not word aligned completes with rsp_err=1 and no side effects.
module pika_dmem_bank
    import pika_dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = clog2(LANES);
    localparam int IDX_W = clog2(DEPTH_WORDS);
    localparam int TOP_W = IDX_W + OFF_W;
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [CTR_W-1:0] CTR_LOAD = NO_WAIT ? '0 : CTR_W'(WAIT_STATES - 1);

    dmem_state_e state;

    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [LANES-1:0]  lat_be;

    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [LANES-1:0]  c_be;
    logic [IDX_W-1:0]  c_idx;
    logic              c_oor;
    logic              c_err;
    logic [DATA_W-1:0] rdata_nxt;

    logic accept;
    logic commit;
    logic mem_we;
    logic ctr_zero;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    assign accept = req_valid && req_ready;

    // With no wait states the request commits on its own accept edge, so the
    // live inputs are used; otherwise the latched copy is.
    always_comb begin
        c_write = lat_write;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_be    = lat_be;
        if (NO_WAIT) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
    end

    assign c_idx = c_addr[TOP_W-1:OFF_W];
    assign c_oor = |(c_addr >> TOP_W);

`ifdef DMEM_ALIGN_CHECK_EN
    assign c_err = c_oor || ((c_addr & ADDR_W'(LANES - 1)) != '0);
`else
    assign c_err = c_oor;
`endif

    // Commit happens on the edge that enters RESP.
    assign commit    = NO_WAIT ? accept : ((state == S_WAIT) && ctr_zero);
    assign mem_we    = commit && c_write && !c_err;
    assign rdata_nxt = (c_write || c_err) ? '0 : mem[c_idx];

    pika_dmem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && !NO_WAIT),
        .load_val (CTR_LOAD),
        .dec      (state == S_WAIT),
        .zero     (ctr_zero)
    );

    // Capture the request on accept for the wait-state path.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Byte-lane store into the array; reset blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (c_be[i]) mem[c_idx][i*8 +: 8] <= c_wdata[i*8 +: 8];
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        if (NO_WAIT) begin
                            state <= S_RESP;
                        end else begin
                            state     <= S_WAIT;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (ctr_zero) begin
                        state     <= S_RESP;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_nxt;
                rsp_err   <= c_err;
            end
        end
    end

endmodule

// File: tb/tb_pika_dmem_bank.sv
// Scoreboard bench for pika_dmem_bank: three instances (WAIT_STATES 1, 0, 3)
// share a clock, each with its own driver, word-array reference model and
// response monitor.
module tb_pika_dmem_bank;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        typedef struct {
            logic [31:0] rdata;
            logic        err;
            int          acc;
        } exp_t;

        logic        rst_n;
        logic        req_valid;
        logic        req_ready;
        logic        req_write;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic [3:0]  req_be;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        logic        busy;

        exp_t        q[$];
        int          inflight = 0;
        bit          mon_en = 0;
        bit          fin = 0;
        logic [31:0] model [256];

        pika_dmem_bank #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .DEPTH_WORDS (256),
            .WAIT_STATES (WS)
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_be    (req_be),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .busy      (busy)
        );

        // Reference: a 256-word array; anything at or above 0x400 is an error.
        function automatic exp_t predict(input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] be);
            exp_t e;
            logic bad;
            int   idx;
            bad = (a >= 32'h400);
`ifdef DMEM_ALIGN_CHECK_EN
            if ((a % 4) != 0) bad = 1'b1;
`endif
            e.err   = bad;
            e.rdata = 32'h0;
            e.acc   = 0;
            if (!bad) begin
                idx = int'(a / 4);
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
                end else begin
                    e.rdata = model[idx];
                end
            end
            return e;
        endfunction

        // Called at a negedge; returns at the negedge after the accept edge.
        task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int acc);
            int   t;
            exp_t e;
            t = 0;
            req_valid = 1'b1;
            req_write = w;
            req_addr  = a;
            req_wdata = d;
            req_be    = be;
            while (!req_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!req_ready) begin
                check($sformatf("cfg%0d_ready_timeout", g), 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                acc = -1;
                return;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            inflight++;
            e = predict(w, a, d, be);
            e.acc = acc;
            q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
        endtask

        task automatic drain();
            int t;
            t = 0;
            while (q.size() != 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("cfg%0d_drain", g), 32'(q.size()), 32'd0);
        endtask

        // Monitor: handshake/busy every cycle, response payload and latency on rsp_valid.
        always @(negedge clk) begin : mon
            exp_t e;
            logic exp_busy;
            if (mon_en) begin
                exp_busy = (inflight > 0) && !rsp_valid;
                check($sformatf("cfg%0d_busy", g), 32'(busy), 32'(exp_busy));
                check($sformatf("cfg%0d_ready", g), 32'(req_ready), 32'(!exp_busy));
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("cfg%0d_unexpected_rsp", g), 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("cfg%0d_rdata", g), rsp_rdata, e.rdata);
                        check($sformatf("cfg%0d_err", g), 32'(rsp_err), 32'(e.err));
                        // Response is captured by the edge WS+1 cycles after accept.
                        check($sformatf("cfg%0d_latency", g), 32'(cyc + 1 - e.acc), 32'(WS + 1));
                    end
                    if (inflight > 0) inflight--;
                end
            end
        end

        initial begin : stim
            int          acc;
            int          acc2;
            int          t;
            logic [31:0] prior;
            logic [31:0] a;
            int          r;

            rst_n     = 1'b0;
            req_valid = 1'b0;
            req_write = 1'b0;
            req_addr  = 32'h0;
            req_wdata = 32'h0;
            req_be    = 4'h0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("cfg%0d_rst_ready", g), 32'(req_ready), 32'd1);
            check($sformatf("cfg%0d_rst_valid", g), 32'(rsp_valid), 32'd0);
            check($sformatf("cfg%0d_rst_busy", g), 32'(busy), 32'd0);
            check($sformatf("cfg%0d_rst_err", g), 32'(rsp_err), 32'd0);
            rst_n  = 1'b1;
            mon_en = 1'b1;

            // Fill every word so later loads have known contents.
            for (int i = 0; i < 256; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, acc);

            issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
            issue(1'b0, 32'h10, 32'h0, 4'h0, acc);
            issue(1'b1, 32'h20, 32'h11223344, 4'hF, acc);
            issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, acc);
            issue(1'b0, 32'h20, 32'h0, 4'h0, acc);
            issue(1'b1, 32'h24, 32'h12345678, 4'h0, acc);
            issue(1'b0, 32'h24, 32'h0, 4'h0, acc);
            issue(1'b0, 32'h400, 32'h0, 4'h0, acc);
            issue(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, acc);
            issue(1'b0, 32'h0, 32'h0, 4'h0, acc);

            // Back-to-back loads: accepts are WS+1 cycles apart.
            issue(1'b0, 32'h10, 32'h0, 4'h0, acc);
            issue(1'b0, 32'h14, 32'h0, 4'h0, acc2);
            check($sformatf("cfg%0d_throughput", g), 32'(acc2 - acc), 32'(WS + 1));

`ifdef DMEM_ALIGN_CHECK_EN
            issue(1'b0, 32'h12, 32'h0, 4'h0, acc);
`endif

            if (WS >= 3) begin
                drain();
                prior = model[12];
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 32'h30;
                req_wdata = 32'h55;
                req_be    = 4'hF;
                t = 0;
                while (!req_ready && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check($sformatf("cfg%0d_abort_ready", g), 32'(req_ready), 32'd1);
                @(posedge clk);
                #1;
                inflight++;
                @(negedge clk);
                req_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                inflight = 0;
                @(negedge clk);
                rst_n = 1'b1;
                check($sformatf("cfg%0d_abort_ready_after", g), 32'(req_ready), 32'd1);
                check($sformatf("cfg%0d_abort_valid_after", g), 32'(rsp_valid), 32'd0);
                check($sformatf("cfg%0d_abort_busy_after", g), 32'(busy), 32'd0);
                repeat (5) @(negedge clk);
                issue(1'b0, 32'h30, 32'h0, 4'h0, acc);
                drain();
                check($sformatf("cfg%0d_abort_model", g), model[12], prior);
            end

            // Randomized traffic with idle gaps and unaccepted valid pulses.
            for (int n = 0; n < 200; n++) begin
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    if (!req_ready && $urandom_range(0, 1) == 1) begin
                        req_valid = 1'b1;
                        req_write = 1'($urandom);
                        req_addr  = $urandom;
                        req_wdata = $urandom;
                        req_be    = 4'($urandom);
                    end else begin
                        req_valid = 1'b0;
                    end
                    @(negedge clk);
                end
                r = int'($urandom_range(0, 9));
                if (r == 0) a = $urandom;
                else a = 32'($urandom_range(0, 255) * 4 + ((r == 1) ? $urandom_range(0, 3) : 0));
                issue(1'($urandom), a, $urandom, 4'($urandom), acc);
            end
            req_valid = 1'b0;
            drain();
            fin = 1'b1;
        end
    end

    initial begin : top
        int t;
        t = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin))
            check("global_timeout", {29'd0, cfg[2].fin, cfg[1].fin, cfg[0].fin}, 32'd7);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
